// File: rtl/microblaze_0_bram_port_arbiter_if.sv
// Requester-side handshake of the BRAM port B arbiter: command, acknowledge
// and completion signals for one requester.
interface microblaze_0_bram_port_arbiter_if #(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4
);
  logic                     Req;
  logic [0:C_PORT_AWIDTH-1] Addr;
  logic [0:C_NUM_WE-1]      WEN;
  logic [0:C_PORT_DWIDTH-1] WrData;
  logic                     Ack;
  logic                     RdValid;
  logic [0:C_PORT_DWIDTH-1] RdData;
  logic                     Err;

  modport master (
    output Req, Addr, WEN, WrData,
    input  Ack, RdValid, RdData, Err
  );

  modport slave (
    input  Req, Addr, WEN, WrData,
    output Ack, RdValid, RdData, Err
  );
endinterface

// File: rtl/microblaze_0_bram_port_arbiter.sv
// Two-requester round-robin arbiter for MicroBlaze BRAM port B with window
// checking, a registered command stage and read-data return routing.
module microblaze_0_bram_port_arbiter #(
  parameter longint unsigned C_BASEADDR    = 64'h0000_0000,
  parameter longint unsigned C_MEMSIZE     = 64'h0000_4000,
  parameter int              C_PORT_DWIDTH = 32,
  parameter int              C_PORT_AWIDTH = 32,
  parameter int              C_NUM_WE      = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Resetn,
  microblaze_0_bram_port_arbiter_if.slave i_req0,
  microblaze_0_bram_port_arbiter_if.slave i_req1,
  output logic                     BRAM_Rst_B,
  output logic                     BRAM_EN_B,
  output logic [0:C_NUM_WE-1]      BRAM_WEN_B,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_B
);

  // Window bounds are one bit wider so BASE + SIZE cannot wrap.
  localparam logic [C_PORT_AWIDTH:0] LP_BASE  = (C_PORT_AWIDTH+1)'(C_BASEADDR);
  localparam logic [C_PORT_AWIDTH:0] LP_LIMIT = LP_BASE + (C_PORT_AWIDTH+1)'(C_MEMSIZE);

  typedef struct packed {
    logic valid;
    logic id;
    logic is_read;
    logic err;
  } tag_t;

  logic                     r_last_grant;
  tag_t                     r_tag1;
  tag_t                     r_tag2;
  logic                     r_en;
  logic [0:C_NUM_WE-1]      r_wen;
  logic [0:C_PORT_AWIDTH-1] r_addr;
  logic [0:C_PORT_DWIDTH-1] r_dout;
  logic [0:1]               r_rdvalid;
  logic [0:1]               r_err;
  logic [0:C_PORT_DWIDTH-1] r_rddata [0:1];

  logic                     w_any_req;
  logic                     w_grant_id;
  logic [0:C_PORT_AWIDTH-1] w_addr;
  logic [0:C_NUM_WE-1]      w_wen;
  logic [0:C_PORT_DWIDTH-1] w_wdata;
  logic [C_PORT_AWIDTH:0]   w_addr_ext;
  logic                     w_in_win;
  logic                     w_is_read;

  always_comb begin
    w_any_req = i_req0.Req | i_req1.Req;
    if (i_req0.Req && i_req1.Req) begin
      w_grant_id = ~r_last_grant;
    end else if (i_req1.Req) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
    if (w_grant_id) begin
      w_addr  = i_req1.Addr;
      w_wen   = i_req1.WEN;
      w_wdata = i_req1.WrData;
    end else begin
      w_addr  = i_req0.Addr;
      w_wen   = i_req0.WEN;
      w_wdata = i_req0.WrData;
    end
    w_addr_ext = {1'b0, w_addr};
    w_in_win   = (w_addr_ext >= LP_BASE) && (w_addr_ext < LP_LIMIT);
    w_is_read  = (w_wen == {C_NUM_WE{1'b0}});
  end

  assign i_req0.Ack = w_any_req & ~w_grant_id & BRAM_Resetn;
  assign i_req1.Ack = w_any_req &  w_grant_id & BRAM_Resetn;

  always_ff @(posedge BRAM_Clk) begin
    if (!BRAM_Resetn) begin
      r_last_grant <= 1'b1;
      r_tag1       <= '0;
      r_tag2       <= '0;
      r_en         <= 1'b0;
      r_wen        <= {C_NUM_WE{1'b0}};
      r_addr       <= {C_PORT_AWIDTH{1'b0}};
      r_dout       <= {C_PORT_DWIDTH{1'b0}};
      r_rdvalid    <= 2'b00;
      r_err        <= 2'b00;
      r_rddata[0]  <= {C_PORT_DWIDTH{1'b0}};
      r_rddata[1]  <= {C_PORT_DWIDTH{1'b0}};
    end else begin
      if (w_any_req) begin
        r_last_grant <= w_grant_id;
        r_tag1       <= {1'b1, w_grant_id, w_is_read, ~w_in_win};
        if (w_in_win) begin
          r_en   <= 1'b1;
          r_wen  <= w_wen;
          r_addr <= {w_addr[0:C_PORT_AWIDTH-3], 2'b00};
          r_dout <= w_wdata;
        end else begin
          r_en  <= 1'b0;
          r_wen <= {C_NUM_WE{1'b0}};
        end
      end else begin
        r_tag1 <= '0;
        r_en   <= 1'b0;
      end
      // Stage 2 tag lines up with BRAM_Din_B; stage 3 routes it home.
      r_tag2 <= r_tag1;
      for (int i = 0; i < 2; i++) begin
        r_rdvalid[i] <= r_tag2.valid && (r_tag2.id == 1'(i)) && r_tag2.is_read;
        r_err[i]     <= r_tag2.valid && (r_tag2.id == 1'(i)) && r_tag2.err;
        if (r_tag2.valid && (r_tag2.id == 1'(i)) && r_tag2.is_read) begin
          r_rddata[i] <= r_tag2.err ? {C_PORT_DWIDTH{1'b0}} : BRAM_Din_B;
        end
      end
    end
  end

  assign BRAM_Rst_B     = 1'b0;
  assign BRAM_EN_B      = r_en;
  assign BRAM_WEN_B     = r_wen;
  assign BRAM_Addr_B    = r_addr;
  assign BRAM_Dout_B    = r_dout;
  assign i_req0.RdValid = r_rdvalid[0];
  assign i_req0.Err     = r_err[0];
  assign i_req0.RdData  = r_rddata[0];
  assign i_req1.RdValid = r_rdvalid[1];
  assign i_req1.Err     = r_err[1];
  assign i_req1.RdData  = r_rddata[1];

endmodule

// File: tb/tb_microblaze_0_bram_port_arbiter.sv
// Scoreboard bench for the BRAM port B arbiter: a behavioural WRITE_FIRST BRAM,
// a reference memory and round-robin model predict every Ack, command and completion.
module tb_microblaze_0_bram_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          due;
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bram_rst, bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr, bram_dout;
  logic [0:31] bram_din;

  microblaze_0_bram_port_arbiter_if if0 ();
  microblaze_0_bram_port_arbiter_if if1 ();

  microblaze_0_bram_port_arbiter dut (
    .BRAM_Clk    (clk),
    .BRAM_Resetn (rst_n),
    .i_req0      (if0),
    .i_req1      (if1),
    .BRAM_Rst_B  (bram_rst),
    .BRAM_EN_B   (bram_en),
    .BRAM_WEN_B  (bram_wen),
    .BRAM_Addr_B (bram_addr),
    .BRAM_Dout_B (bram_dout),
    .BRAM_Din_B  (bram_din)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] bram_mem [0:4095];
  logic [31:0] ref_mem  [0:4095];
  cmd_t        cq0[$], cq1[$];
  sb_t         sq0[$], sq1[$];
  logic        model_last = 1'b1, nx_last = 1'b1;
  logic        exp_en = 1'b0, nx_en = 1'b0;
  logic [31:0] exp_addr, nx_addr, exp_dout, nx_dout;
  logic [3:0]  exp_wen, nx_wen;
  int          ack_cnt0 = 0, ack_cnt1 = 0, cmpl_cnt = 0, first_ack_id = -1;
  logic [31:0] last_rd0 = 32'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    logic [11:0] i12;
    i12 = 12'(idx);
    return {16'hC33C, 4'h0, i12};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural WRITE_FIRST BRAM on port B.
  always @(posedge clk) begin
    logic [31:0] a, w;
    if (bram_en === 1'b1) begin
      a = bram_addr;
      w = merge(bram_mem[a[13:2]], bram_dout, bram_wen);
      bram_mem[a[13:2]] <= w;
      bram_din          <= w;
    end
  end

  task automatic check_cmpl(input int id, input logic v, input logic e, input logic [31:0] d);
    sb_t s;
    int  sz;
    sz = (id == 0) ? sq0.size() : sq1.size();
    if (v || e) begin
      cmpl_cnt++;
      if (id == 0 && v) last_rd0 = d;
      if (sz == 0) begin
        check_eq($sformatf("cmpl%0d_unexpected", id), {v, e}, 2'b00);
      end else begin
        if (id == 0) begin s = sq0[0]; sq0.delete(0); end
        else begin s = sq1[0]; sq1.delete(0); end
        check_eq($sformatf("cmpl%0d_latency", id), cyc, s.due);
        check_eq($sformatf("cmpl%0d_flags", id), {v, e}, {s.is_read, s.err});
        if (s.is_read) check_eq($sformatf("cmpl%0d_data", id), d, s.data);
      end
    end else if (sz != 0) begin
      s = (id == 0) ? sq0[0] : sq1[0];
      if (s.due <= cyc) begin
        if (id == 0) sq0.delete(0); else sq1.delete(0);
        check_eq($sformatf("cmpl%0d_missing", id), {v, e}, {s.is_read, s.err});
      end
    end
  endtask

  // Monitor: predict and compare acks, port B command and completions.
  always @(negedge clk) begin
    logic        e0, e1, id, in_win, is_rd;
    logic [31:0] a, wd;
    logic [3:0]  wn;
    sb_t         s;
    e0 = rst_n && if0.Req && (!if1.Req || model_last);
    e1 = rst_n && if1.Req && (!if0.Req || !model_last);
    check_eq("ack", {if0.Ack, if1.Ack}, {e0, e1});
    if (if0.Ack === 1'b1) ack_cnt0++;
    if (if1.Ack === 1'b1) ack_cnt1++;
    if (!rst_n) first_ack_id = -1;
    else if (first_ack_id < 0 && (if0.Ack === 1'b1 || if1.Ack === 1'b1))
      first_ack_id = (if1.Ack === 1'b1) ? 1 : 0;
    check_eq("bram_en", bram_en, exp_en);
    if (exp_en) begin
      check_eq("bram_addr", bram_addr, exp_addr);
      check_eq("bram_wen", bram_wen, exp_wen);
      check_eq("bram_dout", bram_dout, exp_dout);
    end
    check_cmpl(0, if0.RdValid, if0.Err, if0.RdData);
    check_cmpl(1, if1.RdValid, if1.Err, if1.RdData);
    nx_en   = 1'b0;
    nx_last = model_last;
    if (e0 || e1) begin
      id = e1;
      a  = id ? if1.Addr : if0.Addr;
      wn = id ? if1.WEN : if0.WEN;
      wd = id ? if1.WrData : if0.WrData;
      in_win  = (a < 32'h0000_4000);
      is_rd   = (wn == 4'h0);
      nx_last = id;
      nx_en   = in_win;
      nx_addr = {a[31:2], 2'b00};
      nx_wen  = wn;
      nx_dout = wd;
      if (in_win && !is_rd) ref_mem[a[13:2]] = merge(ref_mem[a[13:2]], wd, wn);
      if (is_rd || !in_win) begin
        s.due     = cyc + 3;
        s.is_read = is_rd;
        s.err     = !in_win;
        s.data    = in_win ? ref_mem[a[13:2]] : 32'h0;
        if (id) sq1.push_back(s); else sq0.push_back(s);
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      sq0.delete();
      sq1.delete();
      model_last = 1'b1;
      exp_en     = 1'b0;
    end else begin
      model_last = nx_last;
      exp_en     = nx_en;
      exp_addr   = nx_addr;
      exp_wen    = nx_wen;
      exp_dout   = nx_dout;
    end
  end

  task automatic apply();
    if0.Req = (cq0.size() != 0);
    if (cq0.size() != 0) begin
      if0.Addr = cq0[0].addr; if0.WEN = cq0[0].wen; if0.WrData = cq0[0].wdata;
    end
    if1.Req = (cq1.size() != 0);
    if (cq1.size() != 0) begin
      if1.Addr = cq1[0].addr; if1.WEN = cq1[0].wen; if1.WrData = cq1[0].wdata;
    end
  endtask

  task automatic drive(input int budget, output int n);
    logic a0, a1;
    n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0) && n < budget) begin
      apply();
      @(negedge clk);
      a0 = if0.Ack;
      a1 = if1.Ack;
      @(posedge clk);
      #1;
      if (a0 === 1'b1 && cq0.size() != 0) cq0.delete(0);
      if (a1 === 1'b1 && cq1.size() != 0) cq1.delete(0);
      n++;
    end
    if0.Req = 1'b0;
    if1.Req = 1'b0;
    check_eq("drive_done", cq0.size() + cq1.size(), 0);
  endtask

  task automatic idle(input int n);
    if0.Req = 1'b0;
    if1.Req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic cmd_t mk(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    cmd_t c;
    c.addr = a; c.wen = w; c.wdata = d;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, cc;
    for (int i = 0; i < 4096; i++) begin
      bram_mem[i] = init_word(i);
      ref_mem[i]  = init_word(i);
    end
    rst_n = 1'b0;
    if0.Req = 1'b0; if0.Addr = '0; if0.WEN = '0; if0.WrData = '0;
    if1.Req = 1'b0; if1.Addr = '0; if1.WEN = '0; if1.WrData = '0;

    // Reset held with both requesting; requester 0 must win first.
    cq0.push_back(mk(32'h0000_0040, 4'h0, 32'h0));
    cq1.push_back(mk(32'h0000_0044, 4'h0, 32'h0));
    apply();
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    drive(10, n);
    idle(5);
    check_eq("first_ack_id", first_ack_id, 0);

    // Single read by requester 1.
    cq1.push_back(mk(32'h0000_0104, 4'h0, 32'h0));
    drive(5, n);
    idle(5);

    // Contention: 8 accesses each, held continuously.
    c0 = ack_cnt0; c1 = ack_cnt1;
    for (int i = 0; i < 8; i++) begin
      cq0.push_back(mk(32'h0000_0200 + 32'(4*i), 4'h0, 32'h0));
      cq1.push_back(mk(32'h0000_0300 + 32'(4*i), 4'h0, 32'h0));
    end
    drive(40, n);
    check_eq("cont_cycles", n, 16);
    check_eq("cont_acks0", ack_cnt0 - c0, 8);
    check_eq("cont_acks1", ack_cnt1 - c1, 8);
    idle(5);

    // Partial-byte write then read back.
    cq0.push_back(mk(32'h0000_0010, 4'b0011, 32'hDEAD_BEEF));
    cq0.push_back(mk(32'h0000_0010, 4'h0, 32'h0));
    drive(10, n);
    idle(5);
    check_eq("wr_rd_merge", last_rd0, 32'hC33C_BEEF);

    // Out-of-window read and write.
    cq0.push_back(mk(32'h0000_4000, 4'h0, 32'h0));
    cq1.push_back(mk(32'hFFFF_FFFC, 4'hF, 32'h1234_5678));
    drive(10, n);
    idle(5);

    // Mixed random traffic, some beyond the window.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [3:0]  w;
      a = 32'($urandom_range(0, 32'h47FF)) & 32'hFFFF_FFFC;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (i % 2 == 0) cq0.push_back(mk(a, w, $urandom));
      else cq1.push_back(mk(a, w, $urandom));
    end
    drive(80, n);
    idle(6);

    // Reset with two reads still in flight.
    cc = cmpl_cnt;
    cq0.push_back(mk(32'h0000_0020, 4'h0, 32'h0));
    cq1.push_back(mk(32'h0000_0024, 4'h0, 32'h0));
    drive(5, n);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    idle(6);
    check_eq("rst_flight_cmpl", cmpl_cnt - cc, 0);

    check_eq("bram_rst_b", bram_rst, 1'b0);
    check_eq("sb_empty", sq0.size() + sq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
